fp_issue_ctrl: RTL and testbench
================================

FP_ISSUE_CTRL -- requirements
Module: fp_issue_ctrl

Interface
REQ-001 Parameter: width, 32, operand/result width.
REQ-002 Parameter: TIMEOUT, 64, max WAIT cycles before abort (2..255).
REQ-003 The block SHALL have a single clock, CLK, and RESET SHALL be asynchronous and active-high.
REQ-004 Ports SHALL be:
- CLK  in  1  clock, rising edge
- RESET  in  1  async active-high reset
- FPReq  in  1  decode stage holds an FP instruction
- FPOp  in  1  0 = add, 1 = multiply
- SrcA  in  width  operand 1
- SrcB  in  width  operand 2
- DestReg  in  4  destination register index
- FP_Busy  in  1  from FPUnit
- FP_Done  in  1  from FPUnit, 1-cycle pulse
- Result  in  width  from FPUnit, valid with FP_Done
- FP_Start  out  1  to FPUnit, 1-cycle pulse
- FPUnitOp  out  1  to FPUnit
- FP_Operand1  out  width  to FPUnit
- FP_Operand2  out  width  to FPUnit
- Stall  out  1  freeze fetch/decode
- FPWE  out  1  register-file write enable, 1-cycle pulse
- FPWA  out  4  write address
- FPWD  out  width  write data
- FPErr  out  1  sticky timeout flag
- FPLat  out  8  WAIT-cycle count of the last completed op

Function
REQ-005 FSM states SHALL be IDLE, ISSUE, WAIT and WB, with IDLE as the reset state.
REQ-006 In IDLE with FPReq=1, the block SHALL latch FPOp, SrcA, SrcB and DestReg into holding registers, then move to ISSUE on the next edge; FPReq=0 SHALL hold the block in IDLE.
REQ-007 Stall SHALL be combinational: 1 when (IDLE and FPReq) or ISSUE or WAIT, otherwise 0.
REQ-008 In ISSUE, FP_Start SHALL be 1 for exactly one cycle, with FPUnitOp/FP_Operand1/FP_Operand2 driven from the holding registers; the next state SHALL be WAIT.
REQ-009 FPUnitOp, FP_Operand1 and FP_Operand2 SHALL stay stable from ISSUE through WB.
REQ-010 In WAIT, an 8-bit counter SHALL clear on entry and increment every cycle.
REQ-011 FP_Done=1 in WAIT SHALL capture Result into FPWD, capture counter+1 into FPLat, and move to WB.
REQ-012 FP_Done SHALL be ignored in IDLE, ISSUE and WB.
REQ-013 FP_Busy SHALL not affect state transitions.
REQ-014 If the counter reaches TIMEOUT-1 in WAIT without FP_Done, the block SHALL set FPErr, return to IDLE without a write, and leave FPWD/FPLat unchanged.
REQ-015 FPErr SHALL clear only on RESET.
REQ-016 In WB, FPWE SHALL be 1 for exactly one cycle with FPWA = latched DestReg and Stall=0; the next state SHALL be IDLE.
REQ-017 FPReq SHALL be ignored in WB, because that cycle belongs to the completing instruction.
REQ-018 Minimum latency: FPReq sampled at edge n -> FP_Start in cycle n+1; FP_Done in cycle k -> FPWE in cycle k+1.
REQ-019 Back-to-back: FPReq asserted in the cycle after WB SHALL start a new issue without any additional idle cycle.

Reset
REQ-020 While RESET=1, the block SHALL hold state=IDLE, the WAIT counter=0 and all holding registers=0.
REQ-021 While RESET=1, FP_Start, FPUnitOp, FP_Operand1, FP_Operand2, Stall, FPWE, FPWA, FPWD, FPErr and FPLat SHALL all be 0; Stall SHALL be forced 0 regardless of FPReq.
REQ-022 RESET asserted during ISSUE/WAIT/WB SHALL abort the operation immediately, with no FPWE pulse after release.
REQ-023 A FP_Done arriving after the abort SHALL be ignored.

Verification
REQ-024 Bench instantiates FPUnit. FPReq=1, FPOp=0, SrcA=0x42400000, SrcB=0x40A00000, DestReg=3 -> exactly one FP_Start; Stall high until WB; FPWE pulse with FPWA=3, FPWD=0x42540000 (53.0).
REQ-025 FPOp=1 with the same operands -> FPWD=0x43700000 (240.0); FPLat equals the FP_Start-to-FP_Done distance.
REQ-026 Back-to-back add 0x42C80000+0x43480000 then multiply of the same operands -> FPWD=0x43960000 then 0x469C4000; exactly one FPWE per instruction; FPReq held through WB causes no duplicate issue.
REQ-027 Stub FPUnit that never pulses FP_Done, TIMEOUT=8 -> after 8 WAIT cycles FPErr=1, Stall=0, no FPWE; FPErr stays 1 across later successful ops.
REQ-028 RESET pulsed mid-WAIT, then a late FP_Done -> all outputs 0, no FPWE, FSM in IDLE.
REQ-029 FP_Done forced during ISSUE -> ignored; the write occurs only on the later FP_Done seen in WAIT.

Source files
------------

// File: rtl/fp_issue_ctrl.sv
// Issue/writeback controller that hands one FP instruction at a time to an external
// FPUnit, stalls the front end meanwhile and aborts with a sticky error on timeout.
module fp_issue_ctrl #(
  parameter int width   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FPReq,
  input  logic             FPOp,
  input  logic [width-1:0] SrcA,
  input  logic [width-1:0] SrcB,
  input  logic [3:0]       DestReg,
  input  logic             FP_Busy,
  input  logic             FP_Done,
  input  logic [width-1:0] Result,
  output logic             FP_Start,
  output logic             FPUnitOp,
  output logic [width-1:0] FP_Operand1,
  output logic [width-1:0] FP_Operand2,
  output logic             Stall,
  output logic             FPWE,
  output logic [3:0]       FPWA,
  output logic [width-1:0] FPWD,
  output logic             FPErr,
  output logic [7:0]       FPLat
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} stateType;

  localparam logic [7:0] lastWait = 8'(TIMEOUT - 1);

  stateType         state;
  logic [7:0]       waitCount;
  logic             opHold;
  logic [width-1:0] aHold;
  logic [width-1:0] bHold;
  logic [3:0]       destHold;

  // The FPUnit reports its own occupancy, but sequencing relies solely on FP_Done.
  logic unusedBusy;
  assign unusedBusy = FP_Busy;

  // FP_Start and FPWE are registered pulses raised on entry to ISSUE and WB.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      waitCount <= 8'd0;
      opHold    <= 1'b0;
      aHold     <= '0;
      bHold     <= '0;
      destHold  <= 4'd0;
      FP_Start  <= 1'b0;
      FPWE      <= 1'b0;
      FPWD      <= '0;
      FPErr     <= 1'b0;
      FPLat     <= 8'd0;
    end else begin
      FP_Start <= 1'b0;
      FPWE     <= 1'b0;
      case (state)
        IDLE: begin
          if (FPReq) begin
            opHold   <= FPOp;
            aHold    <= SrcA;
            bHold    <= SrcB;
            destHold <= DestReg;
            FP_Start <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          waitCount <= 8'd0;
          state     <= WAIT;
        end
        WAIT: begin
          // A completion on the final allowed cycle still wins over the timeout.
          if (FP_Done) begin
            FPWD  <= Result;
            FPLat <= waitCount + 8'd1;
            FPWE  <= 1'b1;
            state <= WB;
          end else if (waitCount == lastWait) begin
            FPErr <= 1'b1;
            state <= IDLE;
          end else begin
            waitCount <= waitCount + 8'd1;
          end
        end
        WB: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign FPUnitOp    = opHold;
  assign FP_Operand1 = aHold;
  assign FP_Operand2 = bHold;
  assign FPWA        = destHold;

  // The writeback cycle releases the front end so the next instruction can be decoded.
  assign Stall = ~RESET & (((state == IDLE) & FPReq) | (state == ISSUE) | (state == WAIT));

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Bench for fp_issue_ctrl: an in-bench FPUnit plus a cycle model of the issue rules,
// exercised by directed scenarios and a randomized run including resets.
module tb_fp_issue_ctrl;

  localparam int W  = 32;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          FPReq = 1'b0;
  logic          FPOp = 1'b0;
  logic [W-1:0]  SrcA = '0;
  logic [W-1:0]  SrcB = '0;
  logic [3:0]    DestReg = 4'd0;
  logic          FP_Busy = 1'b0;
  logic          FP_Done = 1'b0;
  logic [W-1:0]  Result = '0;
  logic          FP_Start;
  logic          FPUnitOp;
  logic [W-1:0]  FP_Operand1;
  logic [W-1:0]  FP_Operand2;
  logic          Stall;
  logic          FPWE;
  logic [3:0]    FPWA;
  logic [W-1:0]  FPWD;
  logic          FPErr;
  logic [7:0]    FPLat;

  int errors = 0;
  int checks = 0;

  fp_issue_ctrl #(.width(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .FPReq(FPReq), .FPOp(FPOp), .SrcA(SrcA), .SrcB(SrcB),
    .DestReg(DestReg), .FP_Busy(FP_Busy), .FP_Done(FP_Done), .Result(Result),
    .FP_Start(FP_Start), .FPUnitOp(FPUnitOp), .FP_Operand1(FP_Operand1),
    .FP_Operand2(FP_Operand2), .Stall(Stall), .FPWE(FPWE), .FPWA(FPWA), .FPWD(FPWD),
    .FPErr(FPErr), .FPLat(FPLat)
  );

  always #5 CLK = ~CLK;

  // Reference model: which phase the single outstanding instruction is in.
  bit          mIssuing = 0;
  bit          mWaiting = 0;
  bit          mWriteback = 0;
  bit          mErr = 0;
  int          mWaited = 0;
  bit          mOp = 0;
  logic [31:0] mA = '0;
  logic [31:0] mB = '0;
  logic [3:0]  mDest = '0;
  logic [31:0] mWd = '0;
  logic [7:0]  mLat = '0;

  // FPUnit state: cycles until it answers (0 means it never will).
  int          fpuLatency = 1;
  int          fpuCountdown = 0;
  bit          fpuOp = 0;
  logic [31:0] fpuA = '0;
  logic [31:0] fpuB = '0;
  bit          resetLevel = 1;

  function automatic real toReal(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = 11'(f[30:23]) + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] toSingle(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fpCompute(input bit op, input logic [31:0] a, input logic [31:0] b);
    return op ? toSingle(toReal(a) * toReal(b)) : toSingle(toReal(a) + toReal(b));
  endfunction

  function automatic logic [31:0] randFloat();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)), 23'($urandom)};
  endfunction

  function automatic void modelReset();
    mIssuing = 0; mWaiting = 0; mWriteback = 0; mErr = 0; mWaited = 0;
    mOp = 0; mA = '0; mB = '0; mDest = '0; mWd = '0; mLat = '0;
  endfunction

  function automatic void modelStep();
    if (RESET) begin
      modelReset();
    end else if (mWriteback) begin
      mWriteback = 0;
    end else if (mIssuing) begin
      mIssuing = 0;
      mWaiting = 1;
      mWaited  = 0;
    end else if (mWaiting) begin
      if (FP_Done) begin
        mWd = Result;
        mLat = 8'(mWaited + 1);
        mWaiting = 0;
        mWriteback = 1;
      end else if (mWaited + 1 == TO) begin
        mErr = 1;
        mWaiting = 0;
      end else begin
        mWaited++;
      end
    end else if (FPReq) begin
      mOp = FPOp; mA = SrcA; mB = SrcB; mDest = DestReg;
      mIssuing = 1;
    end
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    bit expStall;
    expStall = !RESET && (mIssuing || mWaiting || (!mWriteback && FPReq));
    checkVal("FP_Start", 32'(FP_Start), 32'(mIssuing));
    checkVal("FPUnitOp", 32'(FPUnitOp), 32'(mOp));
    checkVal("FP_Operand1", FP_Operand1, mA);
    checkVal("FP_Operand2", FP_Operand2, mB);
    checkVal("Stall", 32'(Stall), 32'(expStall));
    checkVal("FPWE", 32'(FPWE), 32'(mWriteback));
    checkVal("FPWA", 32'(FPWA), 32'(mDest));
    checkVal("FPWD", FPWD, mWd);
    checkVal("FPErr", 32'(FPErr), 32'(mErr));
    checkVal("FPLat", 32'(FPLat), 32'(mLat));
  endtask

  always @(negedge CLK) checkOutput();

  // FPUnit accepts an operation whenever it sees FP_Start.
  always @(negedge CLK) begin
    if (FP_Start) begin
      fpuCountdown = fpuLatency;
      fpuOp = FPUnitOp;
      fpuA  = FP_Operand1;
      fpuB  = FP_Operand2;
    end
  end

  task automatic applyStimulus(input bit req, input bit op, input logic [31:0] a,
                               input logic [31:0] b, input logic [3:0] dest, input bit forceDone);
    bit          doneNow;
    logic [31:0] res;
    @(posedge CLK);
    modelStep();
    #1;
    RESET = resetLevel;
    if (resetLevel) modelReset();
    doneNow = 0;
    res = $urandom;
    if (fpuCountdown > 0) begin
      fpuCountdown--;
      if (fpuCountdown == 0) begin
        doneNow = 1;
        res = fpCompute(fpuOp, fpuA, fpuB);
      end
    end
    if (forceDone && !doneNow) res = 32'hDEADBEEF;
    FP_Done = doneNow | forceDone;
    Result  = res;
    FP_Busy = (fpuCountdown > 0) ? 1'b1 : 1'($urandom_range(0, 1));
    FPReq = req; FPOp = op; SrcA = a; SrcB = b; DestReg = dest;
  endtask

  task automatic runOp(input bit op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] dest, input int lat, input bit holdReq, input bit injectIssueDone,
                       output logic [31:0] wd, output logic [3:0] wa, output logic [7:0] latOut,
                       output int starts, output int wes, output int startAt, output int weAt);
    fpuLatency = lat;
    starts = 0; wes = 0; startAt = -1; weAt = -1;
    wd = '0; wa = '0; latOut = '0;
    for (int c = 0; c < 30 && wes == 0; c++) begin
      applyStimulus(c == 0 || holdReq, op, a, b, dest, injectIssueDone && c == 1);
      if (FP_Start) begin
        starts++;
        if (startAt < 0) startAt = c;
      end
      if (FPWE) begin
        wes++; weAt = c; wd = FPWD; wa = FPWA; latOut = FPLat;
      end
    end
  endtask

  initial begin
    logic [31:0] wd;
    logic [3:0]  wa;
    logic [7:0]  lat;
    int          starts, wes, startAt, weAt, weCount, resetLeft;

    modelReset();
    repeat (2) applyStimulus(1, 1, 32'h1234_5678, 32'h9ABC_DEF0, 4'hF, 0);
    #1;
    checkVal("resetStall", 32'(Stall), 32'd0);
    checkVal("resetStart", 32'(FP_Start), 32'd0);
    checkVal("resetOperand1", FP_Operand1, 32'd0);
    checkVal("resetFPLat", 32'(FPLat), 32'd0);
    resetLevel = 0;
    applyStimulus(0, 0, 32'd0, 32'd0, 4'd0, 0);

    $display("[TB] directed add and multiply");
    runOp(0, 32'h4240_0000, 32'h40A0_0000, 4'd3, 3, 0, 0, wd, wa, lat, starts, wes, startAt, weAt);
    checkVal("addFPWD", wd, 32'h4254_0000);
    checkVal("addFPWA", 32'(wa), 32'd3);
    checkVal("addFPLat", 32'(lat), 32'd3);
    checkVal("addStarts", 32'(starts), 32'd1);
    checkVal("addStartAt", 32'(startAt), 32'd1);
    checkVal("addWeAt", 32'(weAt), 32'd5);
    applyStimulus(0, 0, 32'd0, 32'd0, 4'd0, 0);
    runOp(1, 32'h4240_0000, 32'h40A0_0000, 4'd3, 5, 0, 0, wd, wa, lat, starts, wes, startAt, weAt);
    checkVal("mulFPWD", wd, 32'h4370_0000);
    checkVal("mulFPLat", 32'(lat), 32'd5);
    checkVal("mulWes", 32'(wes), 32'd1);

    $display("[TB] back-to-back with FPReq held");
    runOp(0, 32'h42C8_0000, 32'h4348_0000, 4'd7, 2, 1, 0, wd, wa, lat, starts, wes, startAt, weAt);
    checkVal("b2bAddFPWD", wd, 32'h4396_0000);
    checkVal("b2bAddStarts", 32'(starts), 32'd1);
    runOp(1, 32'h42C8_0000, 32'h4348_0000, 4'd9, 4, 1, 0, wd, wa, lat, starts, wes, startAt, weAt);
    checkVal("b2bMulFPWD", wd, 32'h469C_4000);
    checkVal("b2bMulFPWA", 32'(wa), 32'd9);
    checkVal("b2bMulStarts", 32'(starts), 32'd1);
    checkVal("b2bMulStartAt", 32'(startAt), 32'd1);
    checkVal("b2bMulWes", 32'(wes), 32'd1);
    applyStimulus(0, 0, 32'd0, 32'd0, 4'd0, 0);

    $display("[TB] FP_Done during ISSUE");
    runOp(0, 32'h4240_0000, 32'h40A0_0000, 4'd5, 4, 0, 1, wd, wa, lat, starts, wes, startAt, weAt);
    checkVal("earlyDoneFPWD", wd, 32'h4254_0000);
    checkVal("earlyDoneWeAt", 32'(weAt), 32'd6);
    checkVal("earlyDoneFPLat", 32'(lat), 32'd4);

    $display("[TB] timeout");
    runOp(1, 32'h42C8_0000, 32'h4348_0000, 4'd2, 0, 0, 0, wd, wa, lat, starts, wes, startAt, weAt);
    #1;
    checkVal("timeoutWes", 32'(wes), 32'd0);
    checkVal("timeoutFPErr", 32'(FPErr), 32'd1);
    checkVal("timeoutStall", 32'(Stall), 32'd0);
    checkVal("timeoutFPWD", FPWD, 32'h4254_0000);
    checkVal("timeoutFPLat", 32'(FPLat), 32'd4);
    runOp(1, 32'h42C8_0000, 32'h4348_0000, 4'd4, 2, 0, 0, wd, wa, lat, starts, wes, startAt, weAt);
    checkVal("afterErrFPWD", wd, 32'h469C_4000);
    checkVal("afterErrFPErr", 32'(FPErr), 32'd1);

    $display("[TB] reset during WAIT with late FP_Done");
    fpuLatency = 6;
    applyStimulus(1, 0, 32'h4240_0000, 32'h40A0_0000, 4'd6, 0);
    repeat (3) applyStimulus(0, 0, 32'd0, 32'd0, 4'd0, 0);
    resetLevel = 1;
    applyStimulus(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 0);
    #1;
    checkVal("abortStall", 32'(Stall), 32'd0);
    checkVal("abortFPErr", 32'(FPErr), 32'd0);
    checkVal("abortFPWD", FPWD, 32'd0);
    applyStimulus(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 0);
    resetLevel = 0;
    weCount = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(0, 0, 32'd0, 32'd0, 4'd0, 0);
      if (FPWE) weCount++;
    end
    #1;
    checkVal("abortWes", 32'(weCount), 32'd0);
    checkVal("abortIdleStall", 32'(Stall), 32'd0);
    checkVal("abortFPLat", 32'(FPLat), 32'd0);

    $display("[TB] randomized traffic");
    resetLeft = 0;
    for (int i = 0; i < 1500; i++) begin
      fpuLatency = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
      if (resetLeft > 0) resetLeft--;
      else if ($urandom_range(0, 199) == 0) resetLeft = int'($urandom_range(1, 2));
      resetLevel = (resetLeft > 0);
      applyStimulus($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), randFloat(), randFloat(),
                    4'($urandom), $urandom_range(0, 19) == 0);
    end
    resetLevel = 0;
    repeat (2) applyStimulus(0, 0, 32'd0, 32'd0, 4'd0, 0);
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
